// File: rtl/ltpi_pattern_pkg.sv
// Shared types and constants for the LTPI GPIO pattern engine.
package ltpi_pattern_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        TOGGLE = 2'd1,
        WALK   = 2'd2,
        LFSR   = 2'd3
    } pattern_mode_t;

    localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
    // Taps 32,22,2,1 expressed as bit positions 31,21,1,0
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // One Fibonacci step: shift left, feedback XOR of tapped bits into bit 0
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ltpi_pattern_checker.sv
// Loopback checker: counts mismatches between expected and received
// vectors on each compare strobe; saturating counter plus sticky flag.
module ltpi_pattern_checker #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ERR_W = 16
) (
    input  logic             clk_60m,
    input  logic             rst_n,
    input  logic             i_cmp_stb,
    input  logic [WIDTH-1:0] i_expected,
    input  logic [WIDTH-1:0] i_received,
    input  logic             i_clear,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic             o_err_flag
);

    logic [ERR_W-1:0] r_err_cnt;
    logic             r_err_flag;
    logic             w_mismatch;

    assign w_mismatch = i_cmp_stb && (i_expected != i_received);

    // Error accounting; clear has priority over a simultaneous mismatch
    always_ff @(posedge clk_60m or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt  <= '0;
            r_err_flag <= 1'b0;
        end else if (i_clear) begin
            r_err_cnt  <= '0;
            r_err_flag <= 1'b0;
        end else if (w_mismatch) begin
            r_err_flag <= 1'b1;
            if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign o_err_cnt  = r_err_cnt;
    assign o_err_flag = r_err_flag;

endmodule

// File: rtl/ltpi_gpio_pattern_engine.sv
// LTPI GPIO pattern engine: drives a periodic low/high pattern into the
// tunnel and checks the looped-back vector at the end of each phase.
module ltpi_gpio_pattern_engine
    import ltpi_pattern_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned PERIOD    = 5000000,
    parameter int unsigned ASSERT_AT = 250000,
    parameter int unsigned ERR_W     = 16
) (
    input  logic             clk_60m,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             link_aligned,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] pat_out,
    input  logic [WIDTH-1:0] pat_rx,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_flag,
    output logic             period_strobe
);

    localparam int unsigned CNT_W  = $clog2(PERIOD);
    localparam int unsigned WIDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned REP    = (WIDTH + 31) / 32;

    localparam logic [CNT_W-1:0]  C_LAST   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  C_HI_CMP = CNT_W'(PERIOD - 2);
    localparam logic [CNT_W-1:0]  C_ASSERT = CNT_W'(ASSERT_AT);
    localparam logic [CNT_W-1:0]  C_LO_CMP = CNT_W'(ASSERT_AT - 1);
    localparam logic [WIDX_W-1:0] C_WLAST  = WIDX_W'(WIDTH - 1);

    if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
        $error("ltpi_gpio_pattern_engine: WIDTH must be 1..1024");
    end
    if (PERIOD < 8) begin : g_bad_period
        $error("ltpi_gpio_pattern_engine: PERIOD must be >= 8");
    end
    if (ASSERT_AT < 2 || ASSERT_AT > PERIOD - 3) begin : g_bad_assert
        $error("ltpi_gpio_pattern_engine: ASSERT_AT must be in 2..PERIOD-3");
    end

    logic                w_run;
    logic                w_strobe;
    logic                w_cmp;
    logic [WIDTH-1:0]    w_hi_vec;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_pat;
    pattern_mode_t       r_mode_q;
    logic [WIDX_W-1:0]   r_walk_idx;
    logic [31:0]         r_lfsr;
    logic                r_skip_lo;

    assign w_run    = enable && link_aligned;
    assign w_strobe = w_run && (r_cnt == C_LAST);

    // Period counter; held at zero whenever the engine is not running
    always_ff @(posedge clk_60m or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!w_run || r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Mode is only picked up at a period boundary or while idle
    always_ff @(posedge clk_60m or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_q <= OFF;
        end else if (!w_run || w_strobe) begin
            r_mode_q <= pattern_mode_t'(mode);
        end
    end

    // Per-period pattern sources: walking index and LFSR advance at strobe
    always_ff @(posedge clk_60m or negedge rst_n) begin
        if (!rst_n) begin
            r_walk_idx <= '0;
            r_lfsr     <= LFSR_SEED;
        end else if (!w_run) begin
            r_walk_idx <= '0;
            r_lfsr     <= LFSR_SEED;
        end else if (w_strobe) begin
            if (r_mode_q == WALK) begin
                r_walk_idx <= (r_walk_idx == C_WLAST) ? '0 : r_walk_idx + 1'b1;
            end
            if (r_mode_q == LFSR) begin
                r_lfsr <= lfsr_next(r_lfsr);
            end
        end
    end

    // High-phase vector for the current mode
    always_comb begin
        w_hi_vec = '0;
        case (r_mode_q)
            TOGGLE:  w_hi_vec = '1;
            WALK:    w_hi_vec = WIDTH'(1) << r_walk_idx;
            LFSR:    w_hi_vec = WIDTH'({REP{r_lfsr}});
            default: w_hi_vec = '0;
        endcase
    end

    // Pattern output register: rises at ASSERT_AT, falls at period end
    always_ff @(posedge clk_60m or negedge rst_n) begin
        if (!rst_n) begin
            r_pat <= '0;
        end else if (!w_run) begin
            r_pat <= '0;
        end else if (r_cnt == C_ASSERT) begin
            r_pat <= w_hi_vec;
        end else if (r_cnt == C_LAST) begin
            r_pat <= '0;
        end
    end

    // Loopback is unsettled until one low phase has elapsed after start
    always_ff @(posedge clk_60m or negedge rst_n) begin
        if (!rst_n) begin
            r_skip_lo <= 1'b1;
        end else if (!w_run) begin
            r_skip_lo <= 1'b1;
        end else if (r_cnt == C_LO_CMP) begin
            r_skip_lo <= 1'b0;
        end
    end

    assign w_cmp = w_run && (r_mode_q != OFF) &&
                   (((r_cnt == C_LO_CMP) && !r_skip_lo) || (r_cnt == C_HI_CMP));

    ltpi_pattern_checker #(
        .WIDTH (WIDTH),
        .ERR_W (ERR_W)
    ) u_checker (
        .clk_60m    (clk_60m),
        .rst_n      (rst_n),
        .i_cmp_stb  (w_cmp),
        .i_expected (r_pat),
        .i_received (pat_rx),
        .i_clear    (err_clr),
        .o_err_cnt  (err_cnt),
        .o_err_flag (err_flag)
    );

    assign pat_out       = r_pat;
    assign period_strobe = w_strobe;

endmodule
